// File: rtl/bsg_async_fifo_r_ctrl.sv
// Read-side control of an async FIFO: owns the read pointer and derives
// valid, address, occupancy and a sticky error from the synced write pointer.
module bsg_async_fifo_r_ctrl #(
  parameter int lg_size_p = 4
) (
  input  logic                 r_clk_i,
  input  logic                 r_reset_n_i,
  input  logic [lg_size_p:0]   w_ptr_gray_rsync_i,
  input  logic                 r_yumi_i,
  output logic                 r_valid_o,
  output logic [lg_size_p-1:0] r_addr_o,
  output logic [lg_size_p:0]   r_ptr_binary_r_o,
  output logic [lg_size_p:0]   r_ptr_gray_r_o,
  output logic [lg_size_p:0]   r_count_o,
  output logic                 r_error_o
);

  localparam int pw = lg_size_p + 1;
  localparam logic [pw-1:0] one_c  = pw'(1);
  localparam logic [pw-1:0] full_c = {1'b1, {lg_size_p{1'b0}}};

  logic [pw-1:0] w_bin;
  logic [pw-1:0] w_ptr_bin_r;
  logic [pw-1:0] r_ptr_bin_r;
  logic [pw-1:0] r_ptr_gray_r;
  logic [pw-1:0] r_ptr_bin_n;
  logic [pw-1:0] count;
  logic          valid;
  logic          error_r;
  logic          deq;
  logic          underflow;
  logic          overrun;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < pw; i++) begin
      w_bin[i] = ^(w_ptr_gray_rsync_i >> i);
    end
  end

  assign valid       = (r_ptr_bin_r != w_ptr_bin_r);
  assign count       = w_ptr_bin_r - r_ptr_bin_r;
  assign deq         = r_yumi_i & valid;
  assign underflow   = r_yumi_i & ~valid;
  assign overrun     = (count > full_c);
  assign r_ptr_bin_n = r_ptr_bin_r + one_c;

  always_ff @(posedge r_clk_i) begin
    if (!r_reset_n_i) begin
      w_ptr_bin_r  <= '0;
      r_ptr_bin_r  <= '0;
      r_ptr_gray_r <= '0;
      error_r      <= 1'b0;
    end else begin
      w_ptr_bin_r <= w_bin;
      if (deq) begin
        r_ptr_bin_r  <= r_ptr_bin_n;
        r_ptr_gray_r <= r_ptr_bin_n ^ (r_ptr_bin_n >> 1);
      end
      if (underflow || overrun) begin
        error_r <= 1'b1;
      end
    end
  end

  assign r_valid_o        = valid;
  assign r_addr_o         = r_ptr_bin_r[lg_size_p-1:0];
  assign r_ptr_binary_r_o = r_ptr_bin_r;
  assign r_ptr_gray_r_o   = r_ptr_gray_r;
  assign r_count_o        = count;
  assign r_error_o        = error_r;

endmodule

// File: tb/tb_bsg_async_fifo_r_ctrl.sv
// Directed bench for the async FIFO read-side control, lg_size_p = 4.
module tb_bsg_async_fifo_r_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] w_gray;
  logic       yumi;
  logic       valid;
  logic [3:0] addr;
  logic [4:0] bin;
  logic [4:0] gray;
  logic [4:0] count;
  logic       err;

  int checks = 0;
  int errors = 0;

  bsg_async_fifo_r_ctrl #(.lg_size_p(4)) dut (
    .r_clk_i            (clk),
    .r_reset_n_i        (rst_n),
    .w_ptr_gray_rsync_i (w_gray),
    .r_yumi_i           (yumi),
    .r_valid_o          (valid),
    .r_addr_o           (addr),
    .r_ptr_binary_r_o   (bin),
    .r_ptr_gray_r_o     (gray),
    .r_count_o          (count),
    .r_error_o          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    yumi   = 1'b0;
    w_gray = 5'b00000;
    step();
    rst_n = 1'b1;
  endtask

  logic [4:0] prev_gray;

  initial begin
    // reset holds everything at zero despite a live pointer and yumi
    rst_n  = 1'b0;
    w_gray = 5'b00011;
    yumi   = 1'b1;
    step();
    step();
    chk("rst_valid", valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_bin", bin, 0);
    chk("rst_gray", gray, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    yumi  = 1'b0;
    step();
    chk("rel_valid", valid, 1);
    chk("rel_count", count, 2);

    // single entry in and out
    do_reset();
    step();
    chk("empty_valid", valid, 0);
    w_gray = 5'b00001;
    step();
    chk("one_valid", valid, 1);
    chk("one_count", count, 1);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    chk("deq_bin", bin, 1);
    chk("deq_gray", gray, 5'b00001);
    chk("deq_addr", addr, 1);
    chk("deq_valid", valid, 0);
    chk("deq_count", count, 0);
    chk("deq_err", err, 0);

    // underflow: pointer holds, error sticks
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    chk("uf_bin", bin, 1);
    chk("uf_err", err, 1);
    step();
    step();
    chk("uf_sticky", err, 1);
    do_reset();
    chk("uf_clear", err, 0);

    // full, then drain 16
    w_gray = 5'b11000;
    step();
    chk("full_count", count, 16);
    chk("full_valid", valid, 1);
    chk("full_err", err, 0);
    yumi = 1'b1;
    for (int i = 0; i < 16; i++) step();
    yumi = 1'b0;
    chk("drain_bin", bin, 16);
    chk("drain_addr", addr, 0);
    chk("drain_count", count, 0);
    chk("drain_gray", gray, 5'b11000);

    // write side wraps to 0: 16 more entries, read pointer wraps 31->0
    w_gray = 5'b00000;
    step();
    chk("wrap_count", count, 16);
    chk("wrap_err0", err, 0);
    yumi = 1'b1;
    prev_gray = gray;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("gray_1bit", $countones(prev_gray ^ gray), 1);
      prev_gray = gray;
    end
    yumi = 1'b0;
    chk("wrap_bin", bin, 0);
    chk("wrap_gray", gray, 5'b00000);
    chk("wrap_valid", valid, 0);
    chk("wrap_err", err, 0);

    // dequeue while the write pointer advances by 2
    do_reset();
    w_gray = 5'b00010;
    step();
    chk("sim_count3", count, 3);
    w_gray = 5'b00111;
    yumi   = 1'b1;
    step();
    yumi = 1'b0;
    chk("sim_bin", bin, 1);
    chk("sim_count4", count, 4);

    // corrupt pointer: binary 20 is Gray 11110
    do_reset();
    w_gray = 5'b11110;
    step();
    chk("bad_count", count, 20);
    step();
    chk("bad_err", err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
